// File: rtl/I3CCSR_pkg.sv
// CSR register-block geometry shared by the CPU interface bridges.
package I3CCSR_pkg;
    localparam int I3CCSR_MIN_ADDR_WIDTH = 12;
    localparam int I3CCSR_DATA_WIDTH     = 32;
endpackage

// File: rtl/cpuif_axi_lite_master.sv
// Bridges single-cycle CSR requests onto an AXI-Lite manager port, one transaction at a time.
// Latency: accept -> ack is 3 cycles against a zero-wait subordinate, plus any AXI wait states.
// Backpressure: both stalls stay high from accept until the ack cycle; stalled requests are ignored.
module cpuif_axi_lite_master #(
    parameter int                          AxiLiteAddrWidth = 32,
    parameter int                          AxiLiteDataWidth = 32,
    parameter logic [AxiLiteAddrWidth-1:0] BaseAddr         = '0,
    parameter logic [2:0]                  AxProt           = 3'b000,
    localparam int                         CsrAddrWidth     = I3CCSR_pkg::I3CCSR_MIN_ADDR_WIDTH,
    localparam int                         CsrDataWidth     = I3CCSR_pkg::I3CCSR_DATA_WIDTH
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            s_cpuif_req,
    input  logic                            s_cpuif_req_is_wr,
    input  logic [CsrAddrWidth-1:0]         s_cpuif_addr,
    input  logic [CsrDataWidth-1:0]         s_cpuif_wr_data,
    input  logic [CsrDataWidth-1:0]         s_cpuif_wr_biten,
    output logic                            s_cpuif_req_stall_wr,
    output logic                            s_cpuif_req_stall_rd,
    output logic                            s_cpuif_rd_ack,
    output logic                            s_cpuif_rd_err,
    output logic [CsrDataWidth-1:0]         s_cpuif_rd_data,
    output logic                            s_cpuif_wr_ack,
    output logic                            s_cpuif_wr_err,
    output logic                            awvalid_o,
    input  logic                            awready_i,
    output logic [AxiLiteAddrWidth-1:0]     awaddr_o,
    output logic [2:0]                      awprot_o,
    output logic                            wvalid_o,
    input  logic                            wready_i,
    output logic [AxiLiteDataWidth-1:0]     wdata_o,
    output logic [AxiLiteDataWidth/8-1:0]   wstrb_o,
    input  logic                            bvalid_i,
    output logic                            bready_o,
    input  logic [1:0]                      bresp_i,
    output logic                            arvalid_o,
    input  logic                            arready_i,
    output logic [AxiLiteAddrWidth-1:0]     araddr_o,
    output logic [2:0]                      arprot_o,
    input  logic                            rvalid_i,
    output logic                            rready_o,
    input  logic [AxiLiteDataWidth-1:0]     rdata_i,
    input  logic [1:0]                      rresp_i
);
    localparam int StrbWidth = AxiLiteDataWidth / 8;
    localparam int ExtWidth  = (AxiLiteAddrWidth > CsrAddrWidth) ? AxiLiteAddrWidth : CsrAddrWidth;

    if (AxiLiteDataWidth != 32) begin : g_bad_data_width
        $error("cpuif_axi_lite_master: AxiLiteDataWidth must be 32");
    end
    if (AxiLiteAddrWidth < 10 || AxiLiteAddrWidth > 64) begin : g_bad_addr_width
        $error("cpuif_axi_lite_master: AxiLiteAddrWidth must be within 10..64");
    end

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WR_ADDR_DATA = 3'd1,
        WR_RESP      = 3'd2,
        RD_ADDR      = 3'd3,
        RD_RESP      = 3'd4
    } state_e;

    state_e                        state_q, state_d;
    logic                          awvalid_q, awvalid_d;
    logic                          wvalid_q, wvalid_d;
    logic [AxiLiteAddrWidth-1:0]   addr_q, addr_d;
    logic [CsrDataWidth-1:0]       wdata_q, wdata_d;
    logic [StrbWidth-1:0]          wstrb_q, wstrb_d;
    logic                          wr_ack_q, wr_ack_d;
    logic                          wr_err_q, wr_err_d;
    logic                          rd_ack_q, rd_ack_d;
    logic                          rd_err_q, rd_err_d;
    logic [CsrDataWidth-1:0]       rd_data_q, rd_data_d;
    logic [ExtWidth-1:0]           addr_sum;
    logic [StrbWidth-1:0]          req_strb;
    logic                          unused_resp;

    // Only bit 1 distinguishes SLVERR/DECERR from OKAY/EXOKAY.
    assign unused_resp = bresp_i[0] ^ rresp_i[0];

    always_comb begin
        addr_sum = ExtWidth'(s_cpuif_addr) + ExtWidth'(BaseAddr);
        req_strb = '0;
        for (int i = 0; i < StrbWidth; i++) begin
            req_strb[i] = |s_cpuif_wr_biten[8*i +: 8];
        end
    end

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wr_ack_d  = 1'b0;
        wr_err_d  = 1'b0;
        rd_ack_d  = 1'b0;
        rd_err_d  = 1'b0;
        rd_data_d = '0;
        case (state_q)
            IDLE: begin
                if (s_cpuif_req) begin
                    addr_d = addr_sum[AxiLiteAddrWidth-1:0];
                    if (s_cpuif_req_is_wr) begin
                        wdata_d   = s_cpuif_wr_data;
                        wstrb_d   = req_strb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_ADDR_DATA;
                    end else begin
                        state_d = RD_ADDR;
                    end
                end
            end
            WR_ADDR_DATA: begin
                // AW and W retire independently; leave once both are gone.
                if (awready_i) awvalid_d = 1'b0;
                if (wready_i)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) state_d = WR_RESP;
            end
            WR_RESP: begin
                if (bvalid_i) begin
                    wr_ack_d = 1'b1;
                    wr_err_d = bresp_i[1];
                    state_d  = IDLE;
                end
            end
            RD_ADDR: begin
                if (arready_i) state_d = RD_RESP;
            end
            RD_RESP: begin
                if (rvalid_i) begin
                    rd_ack_d  = 1'b1;
                    rd_err_d  = rresp_i[1];
                    rd_data_d = rdata_i;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wr_ack_q  <= 1'b0;
            wr_err_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            rd_err_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wr_ack_q  <= wr_ack_d;
            wr_err_q  <= wr_err_d;
            rd_ack_q  <= rd_ack_d;
            rd_err_q  <= rd_err_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign s_cpuif_req_stall_wr = (state_q != IDLE);
    assign s_cpuif_req_stall_rd = (state_q != IDLE);
    assign s_cpuif_wr_ack       = wr_ack_q;
    assign s_cpuif_wr_err       = wr_err_q;
    assign s_cpuif_rd_ack       = rd_ack_q;
    assign s_cpuif_rd_err       = rd_err_q;
    assign s_cpuif_rd_data      = rd_data_q;

    assign awvalid_o = awvalid_q;
    assign awaddr_o  = addr_q;
    assign awprot_o  = AxProt;
    assign wvalid_o  = wvalid_q;
    assign wdata_o   = wdata_q;
    assign wstrb_o   = wstrb_q;
    assign bready_o  = (state_q == WR_RESP);
    assign arvalid_o = (state_q == RD_ADDR);
    assign araddr_o  = addr_q;
    assign arprot_o  = AxProt;
    assign rready_o  = (state_q == RD_RESP);
endmodule

// File: tb/tb_cpuif_axi_lite_master.sv
// Randomized bench: a delay-configurable AXI-Lite subordinate plus a per-request reference
// of expected address, strobes, handshake lengths, latency and ack contents.
module tb_cpuif_axi_lite_master;
    localparam int              AW   = 32;
    localparam int              CAW  = I3CCSR_pkg::I3CCSR_MIN_ADDR_WIDTH;
    localparam logic [AW-1:0]   BASE = 32'h0000_1000;
    localparam logic [2:0]      PROT = 3'b010;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            s_cpuif_req = 1'b0, s_cpuif_req_is_wr = 1'b0;
    logic [CAW-1:0]  s_cpuif_addr = '0;
    logic [31:0]     s_cpuif_wr_data = '0, s_cpuif_wr_biten = '0;
    logic            s_cpuif_req_stall_wr, s_cpuif_req_stall_rd;
    logic            s_cpuif_rd_ack, s_cpuif_rd_err, s_cpuif_wr_ack, s_cpuif_wr_err;
    logic [31:0]     s_cpuif_rd_data;
    logic            awvalid_o, awready_i = 1'b0, wvalid_o, wready_i = 1'b0;
    logic [AW-1:0]   awaddr_o, araddr_o;
    logic [2:0]      awprot_o, arprot_o;
    logic [31:0]     wdata_o, rdata_i = '0;
    logic [3:0]      wstrb_o;
    logic            bvalid_i = 1'b0, bready_o, arvalid_o, arready_i = 1'b0, rvalid_i = 1'b0, rready_o;
    logic [1:0]      bresp_i = '0, rresp_i = '0;

    always #5 clk_i = ~clk_i;

    cpuif_axi_lite_master #(
        .AxiLiteAddrWidth(AW), .AxiLiteDataWidth(32), .BaseAddr(BASE), .AxProt(PROT)
    ) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_cpuif_req(s_cpuif_req), .s_cpuif_req_is_wr(s_cpuif_req_is_wr),
        .s_cpuif_addr(s_cpuif_addr), .s_cpuif_wr_data(s_cpuif_wr_data),
        .s_cpuif_wr_biten(s_cpuif_wr_biten),
        .s_cpuif_req_stall_wr(s_cpuif_req_stall_wr), .s_cpuif_req_stall_rd(s_cpuif_req_stall_rd),
        .s_cpuif_rd_ack(s_cpuif_rd_ack), .s_cpuif_rd_err(s_cpuif_rd_err),
        .s_cpuif_rd_data(s_cpuif_rd_data),
        .s_cpuif_wr_ack(s_cpuif_wr_ack), .s_cpuif_wr_err(s_cpuif_wr_err),
        .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o), .awprot_o(awprot_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
        .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i),
        .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o), .arprot_o(arprot_o),
        .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .rresp_i(rresp_i)
    );

    typedef struct {
        logic           is_wr;
        logic [CAW-1:0] addr;
        logic [31:0]    data;
        logic [31:0]    biten;
        int             aw_dly, w_dly, ar_dly, rsp_dly;
        logic [1:0]     resp;
        logic [31:0]    rdata;
    } txn_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    wstrb;
        int            aw_cyc, w_cyc, ar_cyc;
    } obs_t;

    int   n_chk = 0;
    int   n_pass = 0;
    txn_t cfg_q[$];
    obs_t obs_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic finish_run();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    endtask

    // Subordinate: readies/responses follow the delays of the request that opened the transaction.
    txn_t scur;
    obs_t sobs;
    bit   busy = 1'b0, aw_done, w_done, ar_done;
    int   rsp_cnt;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            awready_i = 0; wready_i = 0; arready_i = 0; bvalid_i = 0; rvalid_i = 0;
            bresp_i = 0; rresp_i = 0; rdata_i = 0;
            busy = 0; cfg_q.delete(); obs_q.delete();
        end else begin
            if (!busy && (awvalid_o || wvalid_o || arvalid_o)) begin
                chk("txn_expected", 64'(cfg_q.size() != 0), 64'(1));
                if (cfg_q.size() != 0) scur = cfg_q.pop_front();
                busy = 1; aw_done = 0; w_done = 0; ar_done = 0; rsp_cnt = 0;
                sobs.addr = '0; sobs.wdata = '0; sobs.wstrb = '0;
                sobs.aw_cyc = 0; sobs.w_cyc = 0; sobs.ar_cyc = 0;
            end
            if (arvalid_o || rready_o)
                chk("no_overlap", 64'(awvalid_o || wvalid_o || bready_o), 64'(0));
            if (bready_o) chk("bready_phase", 64'(busy && scur.is_wr && aw_done && w_done), 64'(1));
            if (rready_o) chk("rready_phase", 64'(busy && !scur.is_wr && ar_done), 64'(1));
            bvalid_i = 0; rvalid_i = 0;
            bresp_i = 2'($urandom); rresp_i = 2'($urandom); rdata_i = $urandom;
            if (busy && scur.is_wr && aw_done && w_done) begin
                bvalid_i = (rsp_cnt >= scur.rsp_dly);
                rsp_cnt++;
                if (bvalid_i) bresp_i = scur.resp;
                if (bvalid_i && bready_o) begin obs_q.push_back(sobs); busy = 0; end
            end
            if (busy && !scur.is_wr && ar_done) begin
                rvalid_i = (rsp_cnt >= scur.rsp_dly);
                rsp_cnt++;
                if (rvalid_i) begin rresp_i = scur.resp; rdata_i = scur.rdata; end
                if (rvalid_i && rready_o) begin obs_q.push_back(sobs); busy = 0; end
            end
            awready_i = 0; wready_i = 0; arready_i = 0;
            if (awvalid_o) begin
                chk("awvalid_after_hs", 64'(aw_done), 64'(0));
                sobs.aw_cyc++;
                awready_i = (sobs.aw_cyc > scur.aw_dly);
                if (awready_i) begin
                    aw_done = 1; sobs.addr = awaddr_o;
                    chk("awprot", 64'(awprot_o), 64'(PROT));
                end
            end
            if (wvalid_o) begin
                chk("wvalid_after_hs", 64'(w_done), 64'(0));
                sobs.w_cyc++;
                wready_i = (sobs.w_cyc > scur.w_dly);
                if (wready_i) begin w_done = 1; sobs.wdata = wdata_o; sobs.wstrb = wstrb_o; end
            end
            if (arvalid_o) begin
                chk("arvalid_after_hs", 64'(ar_done), 64'(0));
                sobs.ar_cyc++;
                arready_i = (sobs.ar_cyc > scur.ar_dly);
                if (arready_i) begin
                    ar_done = 1; sobs.addr = araddr_o;
                    chk("arprot", 64'(arprot_o), 64'(PROT));
                end
            end
        end
    end

    function automatic logic [3:0] ref_strb(input logic [31:0] biten);
        logic [3:0] s;
        for (int i = 0; i < 4; i++) s[i] = (((biten >> (8 * i)) & 32'hFF) != 0);
        return s;
    endfunction

    function automatic int ref_lat(input txn_t t);
        int m;
        m = (t.aw_dly > t.w_dly) ? t.aw_dly : t.w_dly;
        return t.is_wr ? (3 + m + t.rsp_dly) : (3 + t.ar_dly + t.rsp_dly);
    endfunction

    function automatic txn_t mk(input logic w, input logic [CAW-1:0] a, input logic [31:0] d,
                                input logic [31:0] b, input int awd, input int wd, input int ard,
                                input int rd, input logic [1:0] resp, input logic [31:0] rdat);
        txn_t t;
        t.is_wr = w; t.addr = a; t.data = d; t.biten = b;
        t.aw_dly = awd; t.w_dly = wd; t.ar_dly = ard; t.rsp_dly = rd;
        t.resp = resp; t.rdata = rdat;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        logic [31:0] b;
        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 3))
                0:       b[8*i +: 8] = 8'h00;
                1:       b[8*i +: 8] = 8'hFF;
                default: b[8*i +: 8] = 8'($urandom);
            endcase
        end
        return mk(1'($urandom), CAW'($urandom), $urandom, b,
                  int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                  int'($urandom_range(0, 4)), int'($urandom_range(0, 5)),
                  2'($urandom), $urandom);
    endfunction

    task automatic drive(input txn_t t);
        s_cpuif_req       = 1'b1;
        s_cpuif_req_is_wr = t.is_wr;
        s_cpuif_addr      = t.addr;
        s_cpuif_wr_data   = t.is_wr ? t.data : $urandom;
        s_cpuif_wr_biten  = t.biten;
        cfg_q.push_back(t);
    endtask

    // Runs one request from the negedge it is presented until its ack negedge.
    // With has_nxt the following request is held on the port throughout the stall.
    task automatic exec(input txn_t t, input bit pre, input bit has_nxt, input txn_t nxt);
        int   lat;
        bit   acked;
        obs_t o;
        logic [AW-1:0] exp_addr;
        if (!pre) drive(t);
        lat = 0; acked = 0;
        while (!acked && lat < 80) begin
            @(negedge clk_i);
            lat++;
            if (lat == 1) begin
                if (has_nxt) drive(nxt);
                else s_cpuif_req = 1'b0;
            end
            if (s_cpuif_wr_ack || s_cpuif_rd_ack) acked = 1;
            else begin
                chk("stall_busy", 64'({s_cpuif_req_stall_wr, s_cpuif_req_stall_rd}), 64'(2'b11));
                chk("outs_between_acks", 64'({s_cpuif_rd_data, s_cpuif_wr_err, s_cpuif_rd_err}), 64'(0));
            end
        end
        if (!acked) begin
            chk("ack_timeout", 64'(lat), 64'(ref_lat(t)));
            finish_run();
        end
        exp_addr = BASE + AW'(t.addr);
        chk("latency", 64'(lat), 64'(ref_lat(t)));
        chk("wr_ack", 64'(s_cpuif_wr_ack), 64'(t.is_wr));
        chk("rd_ack", 64'(s_cpuif_rd_ack), 64'(!t.is_wr));
        chk("stall_in_ack_cycle", 64'({s_cpuif_req_stall_wr, s_cpuif_req_stall_rd}), 64'(0));
        if (t.is_wr) begin
            chk("wr_err", 64'(s_cpuif_wr_err), 64'(t.resp >= 2'd2));
            chk("rd_data_on_wr", 64'(s_cpuif_rd_data), 64'(0));
        end else begin
            chk("rd_err", 64'(s_cpuif_rd_err), 64'(t.resp >= 2'd2));
            chk("rd_data", 64'(s_cpuif_rd_data), 64'(t.rdata));
        end
        chk("axi_txn_count", 64'(obs_q.size()), 64'(1));
        if (obs_q.size() != 0) begin
            o = obs_q.pop_front();
            chk("axi_addr", 64'(o.addr), 64'(exp_addr));
            if (t.is_wr) begin
                chk("wdata", 64'(o.wdata), 64'(t.data));
                chk("wstrb", 64'(o.wstrb), 64'(ref_strb(t.biten)));
                chk("awvalid_cycles", 64'(o.aw_cyc), 64'(t.aw_dly + 1));
                chk("wvalid_cycles", 64'(o.w_cyc), 64'(t.w_dly + 1));
            end else begin
                chk("arvalid_cycles", 64'(o.ar_cyc), 64'(t.ar_dly + 1));
            end
        end
    endtask

    initial begin
        txn_t cur, nxt, dummy;
        bit   pre, hold;
        dummy = mk(0, '0, 0, 0, 0, 0, 0, 0, 0, 0);

        @(negedge clk_i);
        chk("rst_ctrl", 64'({awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o,
                             s_cpuif_wr_ack, s_cpuif_wr_err, s_cpuif_rd_ack, s_cpuif_rd_err,
                             s_cpuif_req_stall_wr, s_cpuif_req_stall_rd}), 64'(0));
        chk("rst_addr", 64'(awaddr_o), 64'(0));
        chk("rst_wdata_wstrb", 64'({wdata_o, wstrb_o}), 64'(0));
        chk("rst_rd_data", 64'(s_cpuif_rd_data), 64'(0));
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Zero-wait write through BaseAddr, full enables.
        exec(mk(1, 12'h010, 32'hA5A5_0001, 32'hFFFF_FFFF, 0, 0, 0, 0, 2'b00, 0), 0, 0, dummy);
        // Read with a slow R channel.
        exec(mk(0, 12'h020, 0, 0, 0, 0, 0, 5, 2'b00, 32'hDEAD_BEEF), 0, 0, dummy);
        // AW stalls, W goes immediately.
        exec(mk(1, 12'h044, 32'h1234_5678, 32'hFFFF_FFFF, 3, 0, 0, 0, 2'b00, 0), 0, 0, dummy);
        // Partial-byte enable and SLVERR.
        exec(mk(1, 12'h0FC, 32'hCAFE_F00D, 32'h0000_0F00, 0, 0, 0, 0, 2'b10, 0), 0, 0, dummy);
        // Read followed by a write held on the port while stalled.
        nxt = mk(1, 12'h300, 32'h0BAD_CAFE, 32'hFF00_00FF, 1, 2, 0, 1, 2'b11, 0);
        exec(mk(0, 12'h200, 0, 0, 0, 0, 2, 1, 2'b01, 32'h5555_AAAA), 0, 1, nxt);
        exec(nxt, 1, 0, dummy);

        // Reset while AR is waiting.
        drive(mk(0, 12'h080, 0, 0, 0, 0, 6, 0, 2'b00, 32'h1111_2222));
        @(negedge clk_i);
        s_cpuif_req = 1'b0;
        @(negedge clk_i);
        chk("arvalid_before_rst", 64'(arvalid_o), 64'(1));
        #2 rst_ni = 1'b0;
        #1;
        chk("arvalid_async_rst", 64'(arvalid_o), 64'(0));
        chk("outs_async_rst", 64'({awvalid_o, wvalid_o, bready_o, rready_o, s_cpuif_rd_ack,
                                   s_cpuif_req_stall_wr, s_cpuif_req_stall_rd}), 64'(0));
        @(negedge clk_i);
        @(negedge clk_i);
        #2 rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("quiet_after_rst", 64'({s_cpuif_rd_ack, s_cpuif_wr_ack, arvalid_o, awvalid_o}), 64'(0));
        end
        exec(mk(0, 12'h084, 0, 0, 0, 0, 0, 0, 2'b00, 32'h3333_4444), 0, 0, dummy);

        pre = 0;
        cur = rand_txn();
        for (int n = 0; n < 60; n++) begin
            hold = (n < 59) && ($urandom_range(0, 2) == 0);
            nxt = rand_txn();
            exec(cur, pre, hold, nxt);
            if (!hold) begin
                int gap;
                gap = int'($urandom_range(0, 2));
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk_i);
                    chk("ack_single_cycle", 64'({s_cpuif_wr_ack, s_cpuif_rd_ack}), 64'(0));
                end
            end
            pre = hold;
            cur = nxt;
        end
        @(negedge clk_i);
        chk("ack_single_cycle", 64'({s_cpuif_wr_ack, s_cpuif_rd_ack}), 64'(0));
        finish_run();
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
